kfpga_config_loader: RTL and testbench



---
 rtl/kfpga_config_loader.sv | 180 ++++++++++++++++++
 tb/tb_kfpga_config_loader.sv | 473 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kfpga_config_loader.sv
// kfpga_config_loader
//
// Configuration sequencer for the kFPGA serial configuration chain. On start it
// pulls the chain clear (cfg_nreset low), then accepts bitstream words from the
// host and shifts exactly CHAIN_LENGTH bits, LSB first, into the core.
//
// Ports:
//   clock       system clock, rising edge
//   reset       synchronous, active-high reset (does not clear the chain)
//   start       one-cycle load request, honoured in IDLE/DONE/ERROR only
//   word_data   host bitstream word, bit 0 shifted first
//   word_valid  host word valid
//   word_ready  loader can take a word
//   cfg_data    core config_in
//   cfg_enable  core config_enable, one chain shift per high cycle
//   cfg_nreset  core config_nreset, active-low chain clear
//   busy        high in CLEAR, WAIT_WORD, SHIFT
//   done        high in DONE
//   error       high in ERROR (host word timeout)
//
// Handshake: a word transfers on a rising edge where word_valid and word_ready
// are both high. word_ready is a registered output that is high only in
// WAIT_WORD, so it never depends combinationally on word_valid, and a word
// offered in any other state is left untouched for the host.
//
// All outputs are registers updated in the same always_ff as the state, so
// each output reflects the state the machine is in during that cycle.

module kfpga_config_loader #(
  parameter int WORD_WIDTH   = 32,
  parameter int CHAIN_LENGTH = 16384,
  parameter int CLEAR_CYCLES = 4,
  parameter int TIMEOUT      = 1024
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WORD_WIDTH-1:0] word_data,
  input  logic                  word_valid,
  output logic                  word_ready,
  output logic                  cfg_data,
  output logic                  cfg_enable,
  output logic                  cfg_nreset,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam int BC_W = $clog2(CHAIN_LENGTH + 1);
  localparam int TO_W = $clog2(TIMEOUT + 1);
  localparam int WB_W = $clog2(WORD_WIDTH + 1);
  localparam int CC_W = $clog2(CLEAR_CYCLES + 1);

  localparam logic [BC_W-1:0] BIT_COUNT_END  = BC_W'(CHAIN_LENGTH);
  localparam logic [WB_W-1:0] WORD_BIT_END   = WB_W'(WORD_WIDTH);
  localparam logic [TO_W-1:0] TIMEOUT_LAST   = TO_W'(TIMEOUT - 1);
  localparam logic [CC_W-1:0] CLEAR_LAST     = CC_W'(CLEAR_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_CLEAR     = 3'd1,
    S_WAIT_WORD = 3'd2,
    S_SHIFT     = 3'd3,
    S_DONE      = 3'd4,
    S_ERROR     = 3'd5
  } state_t;

  state_t                state;
  logic [WORD_WIDTH-1:0] shreg;
  logic [BC_W-1:0]       bit_count;
  logic [WB_W-1:0]       word_bit;
  logic [TO_W-1:0]       timeout_count;
  logic [CC_W-1:0]       clear_count;

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= S_IDLE;
      shreg         <= '0;
      bit_count     <= '0;
      word_bit      <= '0;
      timeout_count <= '0;
      clear_count   <= '0;
      word_ready    <= 1'b0;
      cfg_data      <= 1'b0;
      cfg_enable    <= 1'b0;
      cfg_nreset    <= 1'b1;
      busy          <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            state         <= S_CLEAR;
            bit_count     <= '0;
            word_bit      <= '0;
            timeout_count <= '0;
            clear_count   <= '0;
            cfg_nreset    <= 1'b0;
            busy          <= 1'b1;
            done          <= 1'b0;
            error         <= 1'b0;
          end
        end

        S_CLEAR: begin
          // clear_count runs 0..CLEAR_CYCLES-1, one value per cycle in CLEAR.
          if (clear_count == CLEAR_LAST) begin
            state         <= S_WAIT_WORD;
            cfg_nreset    <= 1'b1;
            word_ready    <= 1'b1;
            timeout_count <= '0;
          end else begin
            clear_count <= clear_count + CC_W'(1);
          end
        end

        S_WAIT_WORD: begin
          if (word_valid && word_ready) begin
            // Bit 0 goes straight onto cfg_data so the first shift happens
            // in the cycle right after the transfer; shreg keeps the rest.
            state         <= S_SHIFT;
            shreg         <= word_data >> 1;
            cfg_data      <= word_data[0];
            cfg_enable    <= 1'b1;
            word_ready    <= 1'b0;
            bit_count     <= bit_count + BC_W'(1);
            word_bit      <= WB_W'(1);
            timeout_count <= '0;
          end else if (timeout_count == TIMEOUT_LAST) begin
            // TIMEOUT cycles in WAIT_WORD without a word.
            state         <= S_ERROR;
            timeout_count <= timeout_count + TO_W'(1);
            word_ready    <= 1'b0;
            busy          <= 1'b0;
            error         <= 1'b1;
          end else begin
            timeout_count <= timeout_count + TO_W'(1);
          end
        end

        S_SHIFT: begin
          // bit_count and word_bit already include the bit on cfg_data this
          // cycle. Chain completion wins over word exhaustion so a final
          // partial word simply drops its unused upper bits.
          if (bit_count == BIT_COUNT_END) begin
            state      <= S_DONE;
            cfg_enable <= 1'b0;
            cfg_data   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b1;
          end else if (word_bit == WORD_BIT_END) begin
            state         <= S_WAIT_WORD;
            cfg_enable    <= 1'b0;
            cfg_data      <= 1'b0;
            word_ready    <= 1'b1;
            timeout_count <= '0;
          end else begin
            cfg_data  <= shreg[0];
            shreg     <= shreg >> 1;
            bit_count <= bit_count + BC_W'(1);
            word_bit  <= word_bit + WB_W'(1);
          end
        end

        default: begin
          state      <= S_IDLE;
          word_ready <= 1'b0;
          cfg_data   <= 1'b0;
          cfg_enable <= 1'b0;
          cfg_nreset <= 1'b1;
          busy       <= 1'b0;
          done       <= 1'b0;
          error      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_kfpga_config_loader.sv
// Testbench for kfpga_config_loader with WORD_WIDTH=8, CHAIN_LENGTH=20,
// CLEAR_CYCLES=3, TIMEOUT=16. A monitor records every shifted bit and the
// clear pulse length; scenario tasks drive the host side and compare against
// hand-derived expectations held in exp_q.

module tb_kfpga_config_loader;

  localparam int WW = 8;
  localparam int CL = 20;
  localparam int CC = 3;
  localparam int TO = 16;

  // Clock / reset
  logic          clock = 1'b0;
  logic          reset;
  logic          start;
  logic [WW-1:0] word_data;
  logic          word_valid;
  logic          word_ready;
  logic          cfg_data;
  logic          cfg_enable;
  logic          cfg_nreset;
  logic          busy;
  logic          done;
  logic          error;

  always #5 clock = ~clock;

  kfpga_config_loader #(
    .WORD_WIDTH  (WW),
    .CHAIN_LENGTH(CL),
    .CLEAR_CYCLES(CC),
    .TIMEOUT     (TO)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .word_data (word_data),
    .word_valid(word_valid),
    .word_ready(word_ready),
    .cfg_data  (cfg_data),
    .cfg_enable(cfg_enable),
    .cfg_nreset(cfg_nreset),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  // {word_ready, cfg_data, cfg_enable, cfg_nreset, busy, done, error}
  wire [6:0] outs = {word_ready, cfg_data, cfg_enable, cfg_nreset, busy, done, error};
  localparam logic [6:0] RESET_OUTS = 7'b0001000;

  int checks = 0;
  int errors = 0;

  // Monitor: sampled 1 time unit after each rising edge
  logic [0:0] obs_q[$];
  int         en_cyc_q[$];
  int         cyc = 0;
  int         en_count = 0;
  int         leak_count = 0;
  int         ready_cycles = 0;
  int         clr_run = 0;
  int         last_clear_len = 0;
  int         clear_events = 0;

  always @(posedge clock) begin
    #1;
    cyc++;
    if (cfg_enable === 1'b1) begin
      obs_q.push_back(cfg_data);
      en_cyc_q.push_back(cyc);
      en_count++;
    end else if (cfg_data !== 1'b0) begin
      leak_count++;
    end
    if (word_ready === 1'b1) ready_cycles++;
    if (cfg_nreset === 1'b0) begin
      clr_run++;
    end else if (clr_run > 0) begin
      last_clear_len = clr_run;
      clear_events++;
      clr_run = 0;
    end
  end

  // Scoreboard: expected bit stream
  logic [0:0] exp_q[$];

  task automatic push_expected(input logic [WW-1:0] w, input int nbits);
    for (int i = 0; i < nbits; i++) exp_q.push_back(w[i]);
  endtask

  task automatic push_expected_three();
    exp_q.delete();
    push_expected(8'hA5, 8);
    push_expected(8'h3C, 8);
    push_expected(8'h0F, 4);
  endtask

  // Driver tasks (called and returning on a falling edge)
  task automatic pulse_start();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  // Offers w, waits for word_ready (bounded), returns after the transfer edge.
  // word_valid is left high; the caller decides when to drop it.
  task automatic send_word(input logic [WW-1:0] w, output bit ok);
    int t;
    t = 0;
    word_data  = w;
    word_valid = 1'b1;
    while (word_ready !== 1'b1 && t < 100) begin
      @(negedge clock);
      t++;
    end
    ok = (word_ready === 1'b1);
    @(negedge clock);
  endtask

  task automatic wait_done(output bit ok);
    int t;
    t = 0;
    while (done !== 1'b1 && t < 200) begin
      @(negedge clock);
      t++;
    end
    ok = (done === 1'b1);
  endtask

  task automatic send_three_back_to_back(output bit ok);
    bit ok1, ok2, ok3;
    send_word(8'hA5, ok1);
    send_word(8'h3C, ok2);
    send_word(8'h0F, ok3);
    word_valid = 1'b0;
    ok = ok1 && ok2 && ok3;
  endtask

  // Scenarios
  task automatic test_reset();
    int bad;
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    checks++;
    if (outs !== RESET_OUTS) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected %b", outs, RESET_OUTS);
    end
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (outs !== RESET_OUTS) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL idle_hold: got %0d changed cycles expected 0", bad);
    end
    checks++;
    if (en_count != 0) begin
      errors++;
      $display("FAIL idle_enables: got %0d expected 0", en_count);
    end
  endtask

  task automatic test_back_to_back();
    int b0, c0, span;
    bit ok;
    push_expected_three();
    b0 = obs_q.size();
    c0 = clear_events;
    pulse_start();
    checks++;
    if ({cfg_nreset, busy, done} !== 3'b010) begin
      errors++;
      $display("FAIL b2b_enter_clear: got nreset/busy/done %b expected 010", {cfg_nreset, busy, done});
    end
    send_three_back_to_back(ok);
    // keep a word on offer to show nothing more is consumed
    word_data  = 8'hFF;
    word_valid = 1'b1;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL b2b_handshake: got ready timeout expected transfers");
    end
    wait_done(ok);
    repeat (3) @(negedge clock);
    checks++;
    if ({done, busy, error, word_ready} !== 4'b1000) begin
      errors++;
      $display("FAIL b2b_status: got done/busy/error/ready %b expected 1000",
               {done, busy, error, word_ready});
    end
    word_valid = 1'b0;
    checks++;
    if (obs_q.size() - b0 != CL) begin
      errors++;
      $display("FAIL b2b_enable_count: got %0d expected %0d", obs_q.size() - b0, CL);
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[b0 + i] !== exp_q[i]) begin
        errors++;
        $display("FAIL b2b_bit%0d: got %b expected %b", i, obs_q[b0 + i], exp_q[i]);
      end
    end
    // 20 bits plus one bubble after each of the two full words
    span = en_cyc_q[en_cyc_q.size() - 1] - en_cyc_q[b0] + 1;
    checks++;
    if (span != CL + 2) begin
      errors++;
      $display("FAIL b2b_span: got %0d cycles expected %0d", span, CL + 2);
    end
    checks++;
    if (clear_events - c0 != 1 || last_clear_len != CC) begin
      errors++;
      $display("FAIL b2b_clear_len: got %0d (events %0d) expected %0d (events 1)",
               last_clear_len, clear_events - c0, CC);
    end
    checks++;
    if (leak_count != 0) begin
      errors++;
      $display("FAIL b2b_data_idle_zero: got %0d leaks expected 0", leak_count);
    end
  endtask

  task automatic test_gaps();
    logic [WW-1:0] w[3];
    int b0, bad, t;
    bit ok, all_ok;
    w[0] = 8'hA5; w[1] = 8'h3C; w[2] = 8'h0F;
    push_expected_three();
    b0 = obs_q.size();
    bad = 0;
    all_ok = 1'b1;
    pulse_start();
    for (int k = 0; k < 3; k++) begin
      word_valid = 1'b0;
      t = 0;
      while (word_ready !== 1'b1 && t < 100) begin
        @(negedge clock);
        t++;
      end
      repeat (5) begin
        @(negedge clock);
        if (cfg_enable !== 1'b0) bad++;
      end
      send_word(w[k], ok);
      all_ok = all_ok && ok;
    end
    word_valid = 1'b0;
    checks++;
    if (bad != 0 || !all_ok) begin
      errors++;
      $display("FAIL gap_enable_low: got %0d enable cycles in gaps (handshake ok=%0d) expected 0 (1)",
               bad, all_ok);
    end
    wait_done(ok);
    @(negedge clock);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL gap_done: got done=%b busy=%b expected done=1 busy=0", done, busy);
    end
    checks++;
    if (obs_q.size() - b0 != CL) begin
      errors++;
      $display("FAIL gap_enable_count: got %0d expected %0d", obs_q.size() - b0, CL);
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[b0 + i] !== exp_q[i]) begin
        errors++;
        $display("FAIL gap_bit%0d: got %b expected %b", i, obs_q[b0 + i], exp_q[i]);
      end
    end
  endtask

  task automatic test_timeout();
    int b0, rc0, t;
    bit ok;
    exp_q.delete();
    push_expected(8'h5A, 8);
    b0 = obs_q.size();
    pulse_start();
    send_word(8'h5A, ok);
    word_valid = 1'b0;
    rc0 = ready_cycles;
    t = 0;
    while (error !== 1'b1 && t < 100) begin
      @(negedge clock);
      t++;
    end
    checks++;
    if ({error, busy, cfg_enable, done} !== 4'b1000) begin
      errors++;
      $display("FAIL timeout_status: got error/busy/enable/done %b expected 1000",
               {error, busy, cfg_enable, done});
    end
    checks++;
    if (ready_cycles - rc0 != TO) begin
      errors++;
      $display("FAIL timeout_wait_cycles: got %0d expected %0d", ready_cycles - rc0, TO);
    end
    checks++;
    if (obs_q.size() - b0 != WW) begin
      errors++;
      $display("FAIL timeout_enable_count: got %0d expected %0d", obs_q.size() - b0, WW);
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[b0 + i] !== exp_q[i]) begin
        errors++;
        $display("FAIL timeout_bit%0d: got %b expected %b", i, obs_q[b0 + i], exp_q[i]);
      end
    end
    // restart from ERROR
    pulse_start();
    checks++;
    if ({error, cfg_nreset, busy} !== 3'b001) begin
      errors++;
      $display("FAIL timeout_restart: got error/nreset/busy %b expected 001",
               {error, cfg_nreset, busy});
    end
    push_expected_three();
    b0 = obs_q.size();
    send_three_back_to_back(ok);
    wait_done(ok);
    checks++;
    if (!ok || obs_q.size() - b0 != CL || last_clear_len != CC) begin
      errors++;
      $display("FAIL timeout_reload: got done=%b enables=%0d clear=%0d expected done=1 enables=%0d clear=%0d",
               done, obs_q.size() - b0, last_clear_len, CL, CC);
    end
  endtask

  task automatic test_reset_mid_load();
    int e0, b0, t;
    bit ok;
    pulse_start();
    e0 = en_count;
    send_word(8'hA5, ok);
    word_valid = 1'b0;
    t = 0;
    while (!(cfg_enable === 1'b1 && en_count - e0 == 3) && t < 50) begin
      @(negedge clock);
      t++;
    end
    checks++;
    if (en_count - e0 != 3) begin
      errors++;
      $display("FAIL midreset_reach_shift3: got %0d enables expected 3", en_count - e0);
    end
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    checks++;
    if (outs !== RESET_OUTS) begin
      errors++;
      $display("FAIL midreset_outputs: got %b expected %b", outs, RESET_OUTS);
    end
    @(negedge clock);
    checks++;
    if (outs !== RESET_OUTS || en_count - e0 != 3) begin
      errors++;
      $display("FAIL midreset_stays_idle: got %b enables=%0d expected %b enables=3",
               outs, en_count - e0, RESET_OUTS);
    end
    push_expected_three();
    b0 = obs_q.size();
    pulse_start();
    send_three_back_to_back(ok);
    wait_done(ok);
    checks++;
    if (!ok || obs_q.size() - b0 != CL || last_clear_len != CC) begin
      errors++;
      $display("FAIL midreset_reload: got done=%b enables=%0d clear=%0d expected done=1 enables=%0d clear=%0d",
               done, obs_q.size() - b0, last_clear_len, CL, CC);
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[b0 + i] !== exp_q[i]) begin
        errors++;
        $display("FAIL midreset_bit%0d: got %b expected %b", i, obs_q[b0 + i], exp_q[i]);
      end
    end
  endtask

  task automatic test_start_handling();
    int b0, c0, span;
    bit ok1, ok2, ok3, ok;
    push_expected_three();
    b0 = obs_q.size();
    c0 = clear_events;
    pulse_start();
    send_word(8'hA5, ok1);
    // now in SHIFT: a start here must be ignored
    pulse_start();
    checks++;
    if ({busy, cfg_nreset, cfg_enable} !== 3'b111) begin
      errors++;
      $display("FAIL start_in_shift: got busy/nreset/enable %b expected 111",
               {busy, cfg_nreset, cfg_enable});
    end
    send_word(8'h3C, ok2);
    send_word(8'h0F, ok3);
    word_valid = 1'b0;
    wait_done(ok);
    checks++;
    if (!(ok1 && ok2 && ok3 && ok) || obs_q.size() - b0 != CL || clear_events - c0 != 1) begin
      errors++;
      $display("FAIL start_ignored_load: got enables=%0d clears=%0d expected enables=%0d clears=1",
               obs_q.size() - b0, clear_events - c0, CL);
    end
    span = en_cyc_q[en_cyc_q.size() - 1] - en_cyc_q[b0] + 1;
    checks++;
    if (span != CL + 2) begin
      errors++;
      $display("FAIL start_ignored_span: got %0d expected %0d", span, CL + 2);
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[b0 + i] !== exp_q[i]) begin
        errors++;
        $display("FAIL start_ignored_bit%0d: got %b expected %b", i, obs_q[b0 + i], exp_q[i]);
      end
    end
    // start from DONE
    pulse_start();
    checks++;
    if ({done, cfg_nreset, busy} !== 3'b001) begin
      errors++;
      $display("FAIL start_in_done: got done/nreset/busy %b expected 001", {done, cfg_nreset, busy});
    end
    b0 = obs_q.size();
    send_three_back_to_back(ok);
    wait_done(ok);
    checks++;
    if (!ok || obs_q.size() - b0 != CL || last_clear_len != CC) begin
      errors++;
      $display("FAIL done_restart_load: got done=%b enables=%0d clear=%0d expected done=1 enables=%0d clear=%0d",
               done, obs_q.size() - b0, last_clear_len, CL, CC);
    end
  endtask

  initial begin
    reset      = 1'b1;
    start      = 1'b0;
    word_data  = '0;
    word_valid = 1'b0;
    test_reset();
    test_back_to_back();
    test_gaps();
    test_timeout();
    test_reset_mid_load();
    test_start_handling();
    repeat (2) @(negedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
